ldtu_ofifo_sched: RTL and testbench
===================================

Name: ldtu_ofifo_sched

Overview:
Sequencer for the LiTe-DTU output FIFO top. Issues read_signal, flush_b and synch toward the FIFO and tracks FIFO occupancy from the CU write strobes. Arbitrates flush and synch requests from the slow-control/TCP decoder: flush has priority over synch, and synch has priority over normal readout. Sits between the CU/control decoder and the output FIFO top; all outputs are registered.

Parameters:
FIFO_DEPTH, 16, number of 38-bit words in the output FIFO
PTR_BITS, 4, log2(FIFO_DEPTH); occupancy is PTR_BITS+1 bits wide
FLUSH_LEN, 4, cycles flush_b is held low per flush request (1..15)
SYNCH_LEN, 8, cycles synch is held high per synch request (1..255)

Ports:
CLK  input  1  LiTe-DTU clock
rst_b  input  1  asynchronous active-low reset
write_signal  input  1  CU write strobe into the FIFO (one word per cycle)
flush_req  input  1  single-cycle flush request
synch_req  input  1  single-cycle synch request
read_en  input  1  downstream serializer ready; gates reads
read_signal  output  1  FIFO read strobe
flush_b  output  1  active-low FIFO flush
synch  output  1  synch-pattern select
occupancy  output  PTR_BITS+1  words held in the FIFO
full_signal  output  1  occupancy == FIFO_DEPTH
overflow  output  1  sticky: a write arrived while full
busy  output  1  high in FLUSH or SYNCH

Behaviour:
- Reset (async, rst_b=0) values:
  - state=RUN; read_signal=0; flush_b=1; synch=0; busy=0.
  - occupancy=0; full_signal=0; overflow=0; pending_synch=0.
- FSM states: RUN, FLUSH, SYNCH. Request latency: an input request sampled at edge N is visible on the outputs after edge N.
- RUN:
  - read_signal = read_en & (occupancy != 0), evaluated on the next-state occupancy.
  - flush_req=1 -> FLUSH, with flush counter loaded to FLUSH_LEN-1.
  - Otherwise synch_req=1 (or pending_synch=1) -> SYNCH, with synch counter loaded to SYNCH_LEN-1; pending_synch is cleared.
- FLUSH:
  - flush_b=0, read_signal=0, busy=1.
  - Counter decrements each cycle. At 0: go to SYNCH if pending_synch, else RUN.
  - On entry: occupancy=0 and overflow=0. Writes during FLUSH are discarded (the FIFO is held in reset), so occupancy stays 0.
  - synch_req during FLUSH sets pending_synch.
  - flush_req during FLUSH reloads the counter (extends the flush).
- SYNCH:
  - synch=1, read_signal=0, busy=1.
  - The FIFO resets on synch, so on entry occupancy=0. Writes during SYNCH are discarded.
  - flush_req during SYNCH aborts immediately to FLUSH, with synch=0 on the next cycle.
  - synch_req during SYNCH reloads the counter.
  - Counter reaches 0 -> RUN.
- Simultaneous flush_req and synch_req in RUN -> FLUSH, and pending_synch is set.
- Occupancy update in RUN, per cycle (rd = read_signal asserted this cycle):
  - write & !rd: +1, saturating at FIFO_DEPTH.
  - !write & rd: -1.
  - write & rd: unchanged.
  - write while occupancy == FIFO_DEPTH and no read: overflow=1 (sticky until flush or reset); occupancy stays FIFO_DEPTH.
  - read_signal is never asserted at occupancy 0, so no underflow is possible.
- full_signal is registered: equals (occupancy == FIFO_DEPTH) in the same cycle.
- Reset mid-FLUSH or mid-SYNCH returns to the reset values asynchronously; no pending request survives reset.

Optional Feature:
LDTU_OFIFO_SCHED_STATS_EN
- Defined: adds output drop_count [15:0] and input clr_stats.
  - drop_count counts writes discarded in FLUSH/SYNCH plus overflow writes.
  - Saturates at 16'hFFFF.
  - Cleared by reset or clr_stats=1. Flush does not clear it.
- Undefined: no drop_count or clr_stats ports, no counter logic; all other behaviour is identical.

Test Plan:
1. Reset, read_en=0, 16 writes, then a 17th -> occupancy=16, full_signal=1, overflow=1, read_signal=0.
2. Occupancy 5, read_en=1, no writes -> read_signal high for exactly 5 cycles, then occupancy=0 and read_signal=0.
3. flush_req pulse at occupancy 10 -> flush_b=0 for 4 cycles starting the next cycle; occupancy=0; overflow cleared; writes during the flush are ignored.
4. flush_req and synch_req in the same cycle -> 4 cycles flush_b=0, then 8 cycles synch=1, then RUN; busy high for 12 cycles.
5. synch_req, then flush_req on the 3rd SYNCH cycle -> synch drops the next cycle, 4-cycle flush follows, then RUN (no synch resumes).
6. With LDTU_OFIFO_SCHED_STATS_EN: 3 writes during SYNCH plus 2 overflow writes -> drop_count=5; clr_stats -> 0.

Source files
------------

// File: rtl/ldtu_ofifo_sched.sv
// LiTe-DTU output FIFO sequencer: read/flush/synch arbitration and occupancy tracking.
// Define LDTU_OFIFO_SCHED_STATS_EN to add the drop_count statistics counter and clr_stats input.
module ldtu_ofifo_sched #(
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_BITS   = 4,
    parameter int FLUSH_LEN  = 4,
    parameter int SYNCH_LEN  = 8
) (
    input  logic                CLK,
    input  logic                rst_b,
    input  logic                write_signal,
    input  logic                flush_req,
    input  logic                synch_req,
    input  logic                read_en,
`ifdef LDTU_OFIFO_SCHED_STATS_EN
    input  logic                clr_stats,
    output logic [15:0]         drop_count,
`endif
    output logic                read_signal,
    output logic                flush_b,
    output logic                synch,
    output logic [PTR_BITS:0]   occupancy,
    output logic                full_signal,
    output logic                overflow,
    output logic                busy
);

    typedef enum logic [1:0] {RUN, FLUSH, SYNCH} state_t;

    localparam logic [PTR_BITS:0] DEPTH      = (PTR_BITS+1)'(FIFO_DEPTH);
    localparam logic [PTR_BITS:0] ONE        = (PTR_BITS+1)'(1);
    localparam logic [7:0]        FLUSH_LOAD = 8'(FLUSH_LEN - 1);
    localparam logic [7:0]        SYNCH_LOAD = 8'(SYNCH_LEN - 1);

    state_t            state, state_nx;
    logic [7:0]        cnt, cnt_nx;
    logic              pend, pend_nx;
    logic [PTR_BITS:0] occ_nx;
    logic              ovf_nx;
    logic              ovf_event;
    logic              drop_event;

    // A synch request that loses to a flush is remembered and served when the flush ends.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pend;
        case (state)
            RUN: begin
                if (flush_req) begin
                    state_nx = FLUSH;
                    cnt_nx   = FLUSH_LOAD;
                    pend_nx  = pend | synch_req;
                end else if (synch_req || pend) begin
                    state_nx = SYNCH;
                    cnt_nx   = SYNCH_LOAD;
                    pend_nx  = 1'b0;
                end
            end
            FLUSH: begin
                if (synch_req)
                    pend_nx = 1'b1;
                if (flush_req) begin
                    cnt_nx = FLUSH_LOAD;
                end else if (cnt == 8'd0) begin
                    if (pend || synch_req) begin
                        state_nx = SYNCH;
                        cnt_nx   = SYNCH_LOAD;
                        pend_nx  = 1'b0;
                    end else begin
                        state_nx = RUN;
                    end
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            SYNCH: begin
                if (flush_req) begin
                    state_nx = FLUSH;
                    cnt_nx   = FLUSH_LOAD;
                    pend_nx  = synch_req;
                end else if (synch_req) begin
                    cnt_nx = SYNCH_LOAD;
                end else if (cnt == 8'd0) begin
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_comb begin
        ovf_event  = (state == RUN) && write_signal && !read_signal && (occupancy == DEPTH);
        drop_event = ovf_event || ((state != RUN) && write_signal);
        occ_nx     = '0;
        ovf_nx     = overflow | ovf_event;
        if (state == RUN) begin
            occ_nx = occupancy;
            if (write_signal && !read_signal && (occupancy != DEPTH))
                occ_nx = occupancy + ONE;
            else if (!write_signal && read_signal)
                occ_nx = occupancy - ONE;
        end
        // The FIFO is held in reset for both flush and synch.
        if (state_nx != RUN)
            occ_nx = '0;
        if (state_nx == FLUSH)
            ovf_nx = 1'b0;
    end

    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b) begin
            state       <= RUN;
            cnt         <= 8'd0;
            pend        <= 1'b0;
            occupancy   <= '0;
            overflow    <= 1'b0;
            full_signal <= 1'b0;
            read_signal <= 1'b0;
            flush_b     <= 1'b1;
            synch       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            pend        <= pend_nx;
            occupancy   <= occ_nx;
            overflow    <= ovf_nx;
            full_signal <= (occ_nx == DEPTH);
            read_signal <= (state_nx == RUN) && read_en && (occ_nx != '0);
            flush_b     <= (state_nx != FLUSH);
            synch       <= (state_nx == SYNCH);
            busy        <= (state_nx != RUN);
        end
    end

`ifdef LDTU_OFIFO_SCHED_STATS_EN
    always_ff @(posedge CLK or negedge rst_b) begin
        if (!rst_b)
            drop_count <= 16'd0;
        else if (clr_stats)
            drop_count <= 16'd0;
        else if (drop_event && (drop_count != 16'hFFFF))
            drop_count <= drop_count + 16'd1;
    end
`else
    logic unused_drop;
    assign unused_drop = drop_event;
`endif

endmodule

// File: tb/tb_ldtu_ofifo_sched.sv
// Randomized self-checking bench for ldtu_ofifo_sched against a cycle-count reference model.
// Honours LDTU_OFIFO_SCHED_STATS_EN when defined.
module tb_ldtu_ofifo_sched;

    localparam int DEPTH = 16;
    localparam int FLEN  = 4;
    localparam int SLEN  = 8;

    logic       CLK = 1'b0;
    logic       rst_b;
    logic       write_signal, flush_req, synch_req, read_en;
    logic       read_signal, flush_b, synch, full_signal, overflow, busy;
    logic [4:0] occupancy;
`ifdef LDTU_OFIFO_SCHED_STATS_EN
    logic        clr_stats;
    logic [15:0] drop_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: remaining cycles of flush/synch, and occupancy as a plain integer.
    int mFlushLeft, mSynchLeft, mPend, mOcc, mOvf, mRd, mDrop;

    ldtu_ofifo_sched dut (
        .CLK          (CLK),
        .rst_b        (rst_b),
        .write_signal (write_signal),
        .flush_req    (flush_req),
        .synch_req    (synch_req),
        .read_en      (read_en),
`ifdef LDTU_OFIFO_SCHED_STATS_EN
        .clr_stats    (clr_stats),
        .drop_count   (drop_count),
`endif
        .read_signal  (read_signal),
        .flush_b      (flush_b),
        .synch        (synch),
        .occupancy    (occupancy),
        .full_signal  (full_signal),
        .overflow     (overflow),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        mFlushLeft = 0; mSynchLeft = 0; mPend = 0;
        mOcc = 0; mOvf = 0; mRd = 0; mDrop = 0;
    endtask

    task automatic modelStep(input bit w, input bit f, input bit s, input bit re, input bit clr);
        int dropped;
        dropped = 0;
        if (mFlushLeft > 0) begin
            if (s) mPend = 1;
            if (f) mFlushLeft = FLEN;
            else   mFlushLeft--;
            if (mFlushLeft == 0 && mPend != 0) begin
                mSynchLeft = SLEN;
                mPend = 0;
            end
            dropped = int'(w);
            mOcc = 0;
        end else if (mSynchLeft > 0) begin
            dropped = int'(w);
            mOcc = 0;
            if (f) begin
                mSynchLeft = 0; mFlushLeft = FLEN; mOvf = 0; mPend = int'(s);
            end else if (s) begin
                mSynchLeft = SLEN;
            end else begin
                mSynchLeft--;
            end
        end else begin
            if (w && mRd == 0 && mOcc == DEPTH) begin
                mOvf = 1;
                dropped = 1;
            end
            mOcc = mOcc + int'(w) - mRd;
            if (mOcc > DEPTH) mOcc = DEPTH;
            if (f) begin
                mFlushLeft = FLEN; mOcc = 0; mOvf = 0; mPend = int'(s);
            end else if (s || mPend != 0) begin
                mSynchLeft = SLEN; mOcc = 0; mPend = 0;
            end
        end
        mRd = int'(mFlushLeft == 0 && mSynchLeft == 0 && re && mOcc != 0);
        if (clr) mDrop = 0;
        else if (dropped != 0 && mDrop < 65535) mDrop++;
    endtask

    task automatic checkAll();
        checkOutput("read_signal", 32'(read_signal), 32'(mRd));
        checkOutput("flush_b",     32'(flush_b),     32'(mFlushLeft == 0));
        checkOutput("synch",       32'(synch),       32'(mSynchLeft > 0));
        checkOutput("busy",        32'(busy),        32'(mFlushLeft > 0 || mSynchLeft > 0));
        checkOutput("occupancy",   32'(occupancy),   32'(mOcc));
        checkOutput("full_signal", 32'(full_signal), 32'(mOcc == DEPTH));
        checkOutput("overflow",    32'(overflow),    32'(mOvf));
`ifdef LDTU_OFIFO_SCHED_STATS_EN
        checkOutput("drop_count",  32'(drop_count),  32'(mDrop));
`endif
    endtask

    task automatic applyStimulus(input bit w, input bit f, input bit s, input bit re, input bit clr);
        write_signal = w; flush_req = f; synch_req = s; read_en = re;
`ifdef LDTU_OFIFO_SCHED_STATS_EN
        clr_stats = clr;
`endif
        @(posedge CLK);
        modelStep(w, f, s, re, clr);
        @(negedge CLK);
        checkAll();
    endtask

    // Called just after a negedge; reset lands mid-cycle, away from any clock edge.
    task automatic doAsyncReset();
        #2 rst_b = 1'b0;
        #1 resetModel();
        checkAll();
        @(negedge CLK);
        rst_b = 1'b1;
    endtask

    initial begin
        int cntA, cntB, cntC;
        rst_b = 1'b0;
        write_signal = 0; flush_req = 0; synch_req = 0; read_en = 0;
`ifdef LDTU_OFIFO_SCHED_STATS_EN
        clr_stats = 0;
`endif
        resetModel();
        #12 checkAll();
        @(negedge CLK);
        rst_b = 1'b1;

        $display("[TB] fill to full and overflow");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t1_occ16", 32'(occupancy), 32'd16);
        checkOutput("t1_full", 32'(full_signal), 32'd1);
        checkOutput("t1_no_ovf", 32'(overflow), 32'd0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t1_ovf", 32'(overflow), 32'd1);
        checkOutput("t1_occ_sat", 32'(occupancy), 32'd16);
        checkOutput("t1_no_read", 32'(read_signal), 32'd0);

        $display("[TB] drain to 10 then flush");
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 0, 1, 0);
        checkOutput("t3_pre_occ", 32'(occupancy), 32'd10);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("t3_flush_low", 32'(flush_b), 32'd0);
        checkOutput("t3_occ0", 32'(occupancy), 32'd0);
        checkOutput("t3_ovf_clr", 32'(overflow), 32'd0);
        cntA = 1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            if (flush_b == 1'b0) cntA++;
        end
        checkOutput("t3_flush_len", 32'(cntA), 32'd4);
        checkOutput("t3_writes_ignored", 32'(occupancy), 32'd0);

        $display("[TB] read out five words");
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0);
        cntA = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 1, 0);
            if (read_signal == 1'b1) cntA++;
        end
        checkOutput("t2_reads", 32'(cntA), 32'd5);
        checkOutput("t2_empty", 32'(occupancy), 32'd0);

        $display("[TB] simultaneous flush and synch");
        cntA = 0; cntB = 0; cntC = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, i == 0, i == 0, 0, 0);
            if (flush_b == 1'b0) cntA++;
            if (synch == 1'b1) cntB++;
            if (busy == 1'b1) cntC++;
        end
        checkOutput("t4_flush_cycles", 32'(cntA), 32'd4);
        checkOutput("t4_synch_cycles", 32'(cntB), 32'd8);
        checkOutput("t4_busy_cycles", 32'(cntC), 32'd12);

        $display("[TB] flush aborts synch");
        cntA = 0; cntB = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, i == 3, i == 0, 0, 0);
            if (flush_b == 1'b0) cntA++;
            if (synch == 1'b1) cntB++;
        end
        checkOutput("t5_flush_cycles", 32'(cntA), 32'd4);
        checkOutput("t5_synch_cycles", 32'(cntB), 32'd3);
        checkOutput("t5_idle", 32'(busy), 32'd0);

`ifdef LDTU_OFIFO_SCHED_STATS_EN
        $display("[TB] drop statistics");
        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1, 0, 0, 0, 0);
        checkOutput("t6_drops", 32'(drop_count), 32'd5);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("t6_clr", 32'(drop_count), 32'd0);
`endif

        $display("[TB] reset during flush with pending synch");
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        doAsyncReset();
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("rst_no_pending_synch", 32'(synch), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3,
                          $urandom_range(0, 99) < 3, $urandom_range(0, 9) < 4,
                          $urandom_range(0, 99) < 2);
            if (i % 700 == 350) doAsyncReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
